// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel-colour generators.
// Frame_Count exists only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;
    logic [15:0] H_Counter_Value;
    logic [15:0] V_Counter_Value;
    logic        Hsync;
    logic        Vsync;
    logic        Video_On;
    logic        Pixel_Tick;
    logic        Frame_Start;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0]  Frame_Count;
`endif

    modport master (
        output H_Counter_Value,
        output V_Counter_Value,
        output Hsync,
        output Vsync,
        output Video_On,
        output Pixel_Tick,
`ifdef VGA_FRAME_COUNT_EN
        output Frame_Count,
`endif
        output Frame_Start
    );

    modport slave (
        input H_Counter_Value,
        input V_Counter_Value,
        input Hsync,
        input Vsync,
        input Video_On,
        input Pixel_Tick,
`ifdef VGA_FRAME_COUNT_EN
        input Frame_Count,
`endif
        input Frame_Start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 by default) with a clock-enable divider.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit wrapping frame counter.
module vga_timing_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_SYNC_W = 16'(H_SYNC);
    localparam logic [15:0] V_SYNC_W = 16'(V_SYNC);
    localparam logic [15:0] H_VIS_LO = 16'(H_SYNC + H_BP);
    localparam logic [15:0] H_VIS_HI = 16'(H_SYNC + H_BP + H_ACT);
    localparam logic [15:0] V_VIS_LO = 16'(V_SYNC + V_BP);
    localparam logic [15:0] V_VIS_HI = 16'(V_SYNC + V_BP + V_ACT);

    logic [DIV_W-1:0] r_div;
    logic [15:0]      r_h;
    logic [15:0]      r_v;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_pixel_tick;
    logic             r_frame_start;

    logic             w_tick;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_frame_wrap;
    logic [15:0]      w_h_nxt;
    logic [15:0]      w_v_nxt;
    logic             w_h_vis;
    logic             w_v_vis;

    assign w_tick       = (r_div == DIV_LAST);
    assign w_h_wrap     = (r_h == H_LAST);
    assign w_v_wrap     = (r_v == V_LAST);
    assign w_frame_wrap = w_tick && w_h_wrap && w_v_wrap;

    always_comb begin
        w_h_nxt = r_h;
        w_v_nxt = r_v;
        if (w_tick) begin
            if (w_h_wrap) begin
                w_h_nxt = 16'd0;
                w_v_nxt = w_v_wrap ? 16'd0 : r_v + 16'd1;
            end else begin
                w_h_nxt = r_h + 16'd1;
            end
        end
    end

    // Decode from next-state counters so sync/blank land on the same edge as the counters.
    assign w_h_vis = (w_h_nxt >= H_VIS_LO) && (w_h_nxt < H_VIS_HI);
    assign w_v_vis = (w_v_nxt >= V_VIS_LO) && (w_v_nxt < V_VIS_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_h           <= 16'd0;
            r_v           <= 16'd0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_video_on    <= 1'b0;
            r_pixel_tick  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_tick ? '0 : r_div + DIV_ONE;
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_hsync       <= (w_h_nxt >= H_SYNC_W);
            r_vsync       <= (w_v_nxt >= V_SYNC_W);
            r_video_on    <= w_h_vis && w_v_vis;
            r_pixel_tick  <= w_tick;
            r_frame_start <= w_frame_wrap;
        end
    end

    assign vga.H_Counter_Value = r_h;
    assign vga.V_Counter_Value = r_v;
    assign vga.Hsync           = r_hsync;
    assign vga.Vsync           = r_vsync;
    assign vga.Video_On        = r_video_on;
    assign vga.Pixel_Tick      = r_pixel_tick;
    assign vga.Frame_Start     = r_frame_start;

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 8'd0;
        end else if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign vga.Frame_Count = r_frame_cnt;
`endif

endmodule
